regfile_wb: RTL and testbench

Parametrised writeback stage and architectural register file for the bf8b core, next generation of the fixed 8-bit/16-register writeback. Accepts one retiring instruction per cycle, commits its result when the opcode produces one, and serves multiple combinational read ports to decode/execute. Adds synchronous reset, a per-register pending (scoreboard) bitmap, out-of-range address protection and a retired-write counter.

---
 rtl/regfile_wb.sv | 125 ++++++++++++
 tb/tb_regfile_wb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// regfile_wb: writeback stage and architectural register file for the bf8b core.
// Commits one retiring result per cycle, tracks a per-register pending bitmap,
// counts committed writes and serves NRD combinational read ports.
// Optional build macro REGFILE_WB_BYPASS_EN: same-cycle forwarding of the
// committing value onto matching read ports (regs output is never bypassed).
module regfile_wb #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREGS   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NRD     = 2,
  parameter logic [3:0]  OP_LOD  = 4'b0001,
  parameter logic [3:0]  OP_ADD  = 4'b0011,
  parameter logic [3:0]  OP_ADDI = 4'b0100,
  parameter logic [3:0]  OP_LODI = 4'b0101,
  parameter logic [3:0]  OP_NAND = 4'b0110
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3:0]              op,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [DATA_W-1:0]       val,
  output logic                    ready,
  input  logic                    busy_set,
  input  logic [ADDR_W-1:0]       busy_addr,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  output logic [NREGS*DATA_W-1:0] regs,
  output logic [15:0]             wb_count
);

  logic [NREGS-1:0][DATA_W-1:0] reg_q, reg_d;
  logic [NREGS-1:0]             pend_q, pend_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic                         ready_q;

  logic                         is_wb_op_c;
  logic [NREGS-1:0]             wr_sel_c;
  logic [NREGS-1:0]             set_sel_c;
  logic                         wr_hit_c;
  logic [NRD-1:0][DATA_W-1:0]   rd_data_c;
  logic [NRD-1:0]               rd_busy_c;

  // Opcodes that produce a register result
  always_comb begin
    is_wb_op_c = 1'b0;
    case (op)
      OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND: is_wb_op_c = 1'b1;
      default:                                    is_wb_op_c = 1'b0;
    endcase
  end

  // One-hot write/set decode; out-of-range addresses select nothing
  always_comb begin
    wr_sel_c  = '0;
    set_sel_c = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      wr_sel_c[i]  = en && is_wb_op_c && (reg_addr == ADDR_W'(i));
      set_sel_c[i] = busy_set && (busy_addr == ADDR_W'(i));
    end
    wr_hit_c = |wr_sel_c;
  end

  // Next state: commit clears pending, a same-edge set overrides the clear
  always_comb begin
    reg_d  = reg_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (wr_sel_c[i]) begin
        reg_d[i]  = val;
        pend_d[i] = 1'b0;
      end
      if (set_sel_c[i]) begin
        pend_d[i] = 1'b1;
      end
    end
    if (wr_hit_c) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ready_q <= en;
    end
  end

  // Combinational read ports; out-of-range addresses read as zero
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          rd_data_c[k] = reg_q[i];
          rd_busy_c[k] = pend_q[i];
        end
      end
`ifdef REGFILE_WB_BYPASS_EN
      if (wr_hit_c && (rd_addr[k*ADDR_W +: ADDR_W] == reg_addr)) begin
        rd_data_c[k] = val;
        rd_busy_c[k] = 1'b0;
      end
`endif
    end
  end

  assign rd_data  = rd_data_c;
  assign rd_busy  = rd_busy_c;
  assign regs     = reg_q;
  assign wb_count = cnt_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb (NREGS=12 to exercise out-of-range).
module tb_regfile_wb;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 12;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NRD    = 2;

  localparam logic [3:0] OP_LOD  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LODI = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [3:0]              op;
  logic [ADDR_W-1:0]       reg_addr;
  logic [DATA_W-1:0]       val;
  logic                    ready;
  logic                    busy_set;
  logic [ADDR_W-1:0]       busy_addr;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_busy;
  logic [NREGS*DATA_W-1:0] regs;
  logic [15:0]             wb_count;

  int checks;
  int errors;

  logic [NREGS*DATA_W-1:0] exp_regs;
  logic [DATA_W-1:0]       exp_byp;

  regfile_wb #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .reg_addr  (reg_addr),
    .val       (val),
    .ready     (ready),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .regs      (regs),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rslot(input int i);
    return regs[i*DATA_W +: DATA_W];
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    exp_regs = '0;
    rst      = 1'b1;
    en       = 1'b1;
    op       = OP_ADDI;
    reg_addr = 4'd1;
    val      = 8'h11;
    busy_set = 1'b0;
    busy_addr = 4'd0;
    rd_addr  = {4'd1, 4'd3};

    // en held during reset is lost
    tick;
    check("rst_ready0", 128'(ready), 128'd0);
    tick;
    check("rst_ready1", 128'(ready), 128'd0);
    check("rst_regs", 128'(regs), 128'd0);
    check("rst_count", 128'(wb_count), 128'd0);
    check("rst_busy", 128'(rd_busy), 128'd0);
    rst = 1'b0;
    en  = 1'b0;
    tick;
    check("idle_ready", 128'(ready), 128'd0);

    // ADDI to reg 3
    en = 1'b1; op = OP_ADDI; reg_addr = 4'd3; val = 8'h5A;
    tick;
    en = 1'b0;
    check("addi_reg3", 128'(rslot(3)), 128'h5A);
    check("addi_rd0", 128'(rd_data[7:0]), 128'h5A);
    check("addi_ready", 128'(ready), 128'd1);
    check("addi_count", 128'(wb_count), 128'd1);

    // Non-writeback opcode to reg 4
    en = 1'b1; op = 4'b0010; reg_addr = 4'd4; val = 8'h77;
    tick;
    en = 1'b0;
    check("nowb_reg4", 128'(rslot(4)), 128'h00);
    check("nowb_ready", 128'(ready), 128'd1);
    check("nowb_count", 128'(wb_count), 128'd1);
    tick;
    check("ready_drop", 128'(ready), 128'd0);

    // Back-to-back commits give continuous ready
    en = 1'b1; op = OP_ADD; reg_addr = 4'd0; val = 8'h01;
    tick;
    check("b2b_ready0", 128'(ready), 128'd1);
    reg_addr = 4'd1; val = 8'h02;
    tick;
    en = 1'b0;
    check("b2b_ready1", 128'(ready), 128'd1);
    check("b2b_count", 128'(wb_count), 128'd3);
    check("b2b_rd1", 128'(rd_data[15:8]), 128'h02);
    tick;
    check("b2b_ready2", 128'(ready), 128'd0);

    // Scoreboard: set on reg 7, then set and commit on the same edge
    busy_set = 1'b1; busy_addr = 4'd7;
    rd_addr = {4'd1, 4'd7};
    tick;
    busy_set = 1'b0;
    check("sb_set", 128'(rd_busy[0]), 128'd1);
    tick;
    tick;
    en = 1'b1; op = OP_LOD; reg_addr = 4'd7; val = 8'h9C;
    busy_set = 1'b1; busy_addr = 4'd7;
    tick;
    en = 1'b0; busy_set = 1'b0;
    check("sb_setwins", 128'(rd_busy[0]), 128'd1);
    check("sb_reg7", 128'(rslot(7)), 128'h9C);
    check("sb_count", 128'(wb_count), 128'd4);

    // Commit alone clears pending
    en = 1'b1; op = OP_LODI; reg_addr = 4'd7; val = 8'h3C;
    tick;
    en = 1'b0;
    check("sb_clear", 128'(rd_busy[0]), 128'd0);
    check("sb_reg7b", 128'(rd_data[7:0]), 128'h3C);

    // Set and commit on different registers
    en = 1'b1; op = OP_ADD; reg_addr = 4'd6; val = 8'h66;
    busy_set = 1'b1; busy_addr = 4'd2;
    rd_addr = {4'd6, 4'd2};
    tick;
    en = 1'b0; busy_set = 1'b0;
    check("diff_busy2", 128'(rd_busy), 128'b01);
    check("diff_rd6", 128'(rd_data[15:8]), 128'h66);
    check("diff_count", 128'(wb_count), 128'd6);

    // Out-of-range busy_set ignored
    busy_set = 1'b1; busy_addr = 4'd13;
    rd_addr = {4'd13, 4'd13};
    tick;
    busy_set = 1'b0;
    check("oor_busy", 128'(rd_busy), 128'd0);

    // Out-of-range commit dropped
    exp_regs[3*DATA_W +: DATA_W] = 8'h5A;
    exp_regs[0*DATA_W +: DATA_W] = 8'h01;
    exp_regs[1*DATA_W +: DATA_W] = 8'h02;
    exp_regs[7*DATA_W +: DATA_W] = 8'h3C;
    exp_regs[6*DATA_W +: DATA_W] = 8'h66;
    en = 1'b1; op = OP_ADD; reg_addr = 4'd13; val = 8'hFF;
    tick;
    en = 1'b0;
    check("oor_regs", 128'(regs), 128'(exp_regs));
    check("oor_ready", 128'(ready), 128'd1);
    check("oor_count", 128'(wb_count), 128'd6);
    check("oor_rd", 128'(rd_data), 128'd0);

    // Same-cycle forwarding on read port 1
    rd_addr = {4'd5, 4'd2};
    en = 1'b1; op = OP_NAND; reg_addr = 4'd5; val = 8'hC3;
`ifdef REGFILE_WB_BYPASS_EN
    exp_byp = 8'hC3;
`else
    exp_byp = 8'h00;
`endif
    #1;
    check("byp_same", 128'(rd_data[15:8]), 128'(exp_byp));
    check("byp_busy", 128'(rd_busy[1]), 128'd0);
    check("byp_regs", 128'(rslot(5)), 128'h00);
    tick;
    en = 1'b0;
    check("byp_next", 128'(rd_data[15:8]), 128'hC3);
    check("byp_count", 128'(wb_count), 128'd7);

    // Count up to 16'hFFFF, then wrap
    en = 1'b1; op = OP_ADDI; reg_addr = 4'd0; val = 8'hA5;
    repeat (65528) @(posedge clk);
    #1;
    en = 1'b0;
    check("cnt_max", 128'(wb_count), 128'hFFFF);
    check("cnt_reg0", 128'(rslot(0)), 128'hA5);
    en = 1'b1;
    tick;
    en = 1'b0;
    check("cnt_wrap", 128'(wb_count), 128'h0000);
    check("cnt_ready", 128'(ready), 128'd1);

    // Reset beats busy_set and en
    rst = 1'b1; busy_set = 1'b1; busy_addr = 4'd4; en = 1'b1;
    rd_addr = {4'd4, 4'd7};
    tick;
    rst = 1'b0; busy_set = 1'b0; en = 1'b0;
    check("rst2_regs", 128'(regs), 128'd0);
    check("rst2_busy", 128'(rd_busy), 128'd0);
    check("rst2_ready", 128'(ready), 128'd0);
    check("rst2_count", 128'(wb_count), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
